// File: rtl/dm_responder.sv
// Data-memory responder: memory-side end of the MEM-stage data port.
// A single-port word array with multi-cycle read latency sits behind a posted-write buffer.
// Reads that hit the buffer are answered next cycle (youngest matching entry wins); misses
// stall the requester for RD_LAT cycles while the array is read. The buffer drains one entry
// per cycle into the array whenever the array port is otherwise idle.
//
// Ports:
//   clk_i        clock, all state on posedge
//   rst_ni       asynchronous reset, active-low
//   req_addr_i   request word address (only the low $clog2(DEPTH) bits are used)
//   req_re_i     read request
//   req_we_i     write request (wins over req_re_i when both are set)
//   req_wdata_i  write data
//   hold_o       combinational stall: request not accepted this cycle
//   rsp_valid_o  registered one-cycle pulse, rsp_rdata_o valid
//   rsp_rdata_o  read data, held until the next rsp_valid_o
//   wb_count_o   posted writes pending
//   err_o        sticky: read and write requested together
module dm_responder #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [AW-1:0]               req_addr_i,
  input  logic                        req_re_i,
  input  logic                        req_we_i,
  input  logic [DW-1:0]               req_wdata_i,
  output logic                        hold_o,
  output logic                        rsp_valid_o,
  output logic [DW-1:0]               rsp_rdata_o,
  output logic [$clog2(WB_DEPTH):0]   wb_count_o,
  output logic                        err_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StRdBusy, StRdDone} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   wb_addr_q [WB_DEPTH];
  logic [DW-1:0]   wb_data_q [WB_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [IW-1:0]   rd_idx_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            err_q;

  logic [IW-1:0]   idx;
  logic            rd_req, req_any, full;
  logic            hit;
  logic [DW-1:0]   hit_data;
  logic            miss_start, miss_acc, hit_acc, push, drain, hold;
  logic            unused_addr;

  // Upper address bits alias onto the array.
  assign idx         = req_addr_i[IW-1:0];
  assign unused_addr = ^req_addr_i[AW-1:IW];
  assign rd_req      = req_re_i & ~req_we_i;
  assign req_any     = req_re_i | req_we_i;
  assign full        = (count_q == CW'(WB_DEPTH));

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0] slot;
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_addr_q[slot] == idx)) begin
        hit      = 1'b1;
        hit_data = wb_data_q[slot];
      end
    end
  end

  // A miss seen in StRdDone is held there and starts on the following idle cycle.
  assign miss_start = (state_q == StIdle) & rd_req & ~hit;
  assign miss_acc   = (state_q == StRdBusy) & (cnt_q == '0);
  assign hit_acc    = (state_q != StRdBusy) & rd_req & hit;
  assign push       = req_we_i & ~hold;
  // The array port is shared: drain only when no miss read owns it.
  assign drain      = (state_q == StIdle) & ~miss_start & (count_q != '0);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (miss_start) begin
          state_d = StRdBusy;
          cnt_d   = LW'(RD_LAT - 1);
        end
      end
      StRdBusy: begin
        if (cnt_q == '0) state_d = StRdDone;
        else             cnt_d   = cnt_q - LW'(1);
      end
      StRdDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs. While busy only the stalled read may be presented; it is released on the
  // last busy cycle.
  always_comb begin
    hold = 1'b0;
    unique case (state_q)
      StIdle, StRdDone: hold = req_we_i ? full : (rd_req & ~hit);
      StRdBusy:         hold = req_any & ((cnt_q != '0) | ~rd_req);
      default:          hold = 1'b0;
    endcase
  end

  // Buffer pointers, response and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_idx_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push)  tail_q <= tail_q + PW'(1);
      if (drain) head_q <= head_q + PW'(1);
      if (push && !drain)      count_q <= count_q + CW'(1);
      else if (drain && !push) count_q <= count_q - CW'(1);
      if (miss_start) rd_idx_q <= idx;
      rsp_valid_q <= hit_acc | miss_acc;
      if (hit_acc)       rsp_rdata_q <= hit_data;
      else if (miss_acc) rsp_rdata_q <= mem_q[rd_idx_q];
      if (req_re_i && req_we_i) err_q <= 1'b1;
    end
  end

  // Buffer payload and array contents carry no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      wb_addr_q[tail_q] <= idx;
      wb_data_q[tail_q] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (drain) mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
  end

  assign hold_o      = hold;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wb_count_o  = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder. A timeline model (buffer queue, word array, cycle at
// which the array port frees up) predicts stall, response and buffer occupancy each cycle.
module tb_dm_responder;

  localparam int unsigned AW       = 16;
  localparam int unsigned DW       = 16;
  localparam int unsigned DEPTH    = 256;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned CW       = $clog2(WB_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] req_addr;
  logic          req_re, req_we;
  logic [DW-1:0] req_wdata;
  logic          hold, rsp_valid, err;
  logic [DW-1:0] rsp_rdata;
  logic [CW-1:0] wb_count;

  always #5 clk = ~clk;

  dm_responder #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .WB_DEPTH(WB_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_addr_i  (req_addr),
    .req_re_i    (req_re),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .hold_o      (hold),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .wb_count_o  (wb_count),
    .err_o       (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model
  ent_t          wbq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] init_val [64];
  int            cyc, port_free, miss_acc_cyc;
  bit            miss_pend;
  logic [7:0]    miss_idx;
  logic          m_rsp_v, m_err;
  logic [DW-1:0] m_rsp_d;

  // Per-cycle observations
  logic          exp_hold, obs_hold, obs_v, obs_err;
  logic [DW-1:0] obs_d;
  logic [CW-1:0] obs_cnt;
  int            peak_cnt;
  bit            div;
  string         div_note;

  task automatic model_reset();
    wbq.delete();
    miss_pend = 0;
    port_free = 0;
    cyc       = 0;
    m_rsp_v   = 1'b0;
    m_rsp_d   = '0;
    m_err     = 1'b0;
  endtask

  // Drive one cycle, record what the DUT shows against the model, then advance the model.
  task automatic step(input bit re, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    logic [7:0]    a8;
    bit            rd, hit, start, drn, rsp_next;
    logic [DW-1:0] hd;
    ent_t          e;
    req_re = re; req_we = we; req_addr = addr; req_wdata = data;
    a8 = addr[7:0];
    rd = re && !we;
    hit = 0; hd = '0;
    foreach (wbq[i]) if (wbq[i].a == a8) begin hit = 1; hd = wbq[i].d; end
    start = 0;
    if (miss_pend)    exp_hold = (re || we) && (cyc != miss_acc_cyc);
    else if (we)      exp_hold = (wbq.size() == WB_DEPTH);
    else if (rd) begin
      exp_hold = !hit;
      start    = !hit && (cyc >= port_free);
    end else          exp_hold = 1'b0;
    drn = !miss_pend && (cyc >= port_free) && !start && (wbq.size() != 0);

    @(negedge clk);
    obs_hold = hold; obs_v = rsp_valid; obs_d = rsp_rdata; obs_cnt = wb_count; obs_err = err;
    if (int'(obs_cnt) > peak_cnt) peak_cnt = int'(obs_cnt);
    if (!div && ({obs_hold, obs_v, obs_err} !== {exp_hold, m_rsp_v, m_err} ||
                 obs_d !== m_rsp_d || obs_cnt !== CW'(wbq.size()))) begin
      div = 1;
      div_note = $sformatf("cyc %0d hold/v/err got %b%b%b want %b%b%b rdata got %h want %h cnt got %0d want %0d",
                           cyc, obs_hold, obs_v, obs_err, exp_hold, m_rsp_v, m_err,
                           obs_d, m_rsp_d, obs_cnt, wbq.size());
    end

    @(posedge clk);
    rsp_next = 0;
    if (miss_pend && cyc == miss_acc_cyc) begin
      rsp_next  = 1;
      m_rsp_d   = ref_mem[miss_idx];
      miss_pend = 0;
      port_free = cyc + 2;
    end else if (rd && hit && !exp_hold) begin
      rsp_next = 1;
      m_rsp_d  = hd;
    end
    if (start) begin
      miss_pend    = 1;
      miss_acc_cyc = cyc + RD_LAT;
      miss_idx     = a8;
    end
    if (drn) begin
      e = wbq.pop_front();
      ref_mem[e.a] = e.d;
    end
    if (we && !exp_hold) wbq.push_back('{a8, data});
    if (re && we) m_err = 1'b1;
    m_rsp_v = rsp_next;
    cyc++;
    #1;
  endtask

  // Present a request until the model says it is accepted; nhold = -1 if it never is.
  task automatic do_req(input bit re, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int nhold);
    nhold = -1;
    for (int k = 0; k < 20; k++) begin
      step(re, we, a, d);
      if (!exp_hold) begin nhold = k; break; end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    req_re = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hold, rsp_valid, err} !== 3'b000 || wb_count !== '0 || rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: hold/v/err=%b%b%b cnt=%0d rdata=%h want all 0",
               hold, rsp_valid, err, wb_count, rsp_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    div = 0;
    idle(5);
    n_checks++;
    if ({obs_hold, obs_v, obs_err} !== 3'b000 || obs_cnt !== '0 || div) begin
      n_fail++;
      $display("FAIL reset_idle: hold/v/err=%b%b%b cnt=%0d want 0 0 0 0 (%s)",
               obs_hold, obs_v, obs_err, obs_cnt, div_note);
    end
  endtask

  task automatic test_init();
    int nh;
    div = 0;
    for (int i = 0; i < 64; i++) begin
      init_val[i] = DW'($urandom);
      do_req(1'b0, 1'b1, AW'(i), init_val[i], nh);
    end
    idle(6);
    n_checks++;
    if (obs_cnt !== '0 || div) begin
      n_fail++;
      $display("FAIL init_drain: cnt=%0d want 0 (%s)", obs_cnt, div_note);
    end
  endtask

  task automatic test_forward();
    int nh;
    div = 0;
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, nh);
    do_req(1'b1, 1'b0, 16'h0010, '0, nh);
    n_checks++;
    if (nh !== 0) begin
      n_fail++;
      $display("FAIL fwd_hold: hold cycles=%0d want 0", nh);
    end
    idle(1);
    n_checks++;
    if (obs_v !== 1'b1 || obs_d !== 16'hBEEF || div) begin
      n_fail++;
      $display("FAIL fwd_data: valid=%b data=%h want 1 beef (%s)", obs_v, obs_d, div_note);
    end
  endtask

  task automatic test_miss_latency();
    int nh;
    idle(6);
    div = 0;
    do_req(1'b1, 1'b0, 16'h0010, '0, nh);
    n_checks++;
    if (nh !== int'(RD_LAT)) begin
      n_fail++;
      $display("FAIL miss_hold: hold cycles=%0d want %0d", nh, RD_LAT);
    end
    idle(1);
    n_checks++;
    if (obs_v !== 1'b1 || obs_d !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL miss_data: valid=%b data=%h want 1 beef", obs_v, obs_d);
    end
    idle(1);
    n_checks++;
    if (obs_v !== 1'b0 || div) begin
      n_fail++;
      $display("FAIL miss_pulse: valid=%b want 0 (%s)", obs_v, div_note);
    end
  endtask

  task automatic test_back_to_back();
    int nh;
    logic [4:0] wr_hold;
    idle(6);
    div = 0;
    peak_cnt = 0;
    wr_hold = '0;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 1'b0, AW'(16'h0038 + i), '0, nh);
      do_req(1'b0, 1'b1, AW'(16'h0020 + i), DW'(16'hA000 + i), nh);
      wr_hold[i] = (nh != 0);
      if (i == 4) begin
        n_checks++;
        if (nh !== 2) begin
          n_fail++;
          $display("FAIL full_hold: 5th write hold cycles=%0d want 2", nh);
        end
      end
    end
    n_checks++;
    if (peak_cnt !== int'(WB_DEPTH) || wr_hold !== 5'b10000) begin
      n_fail++;
      $display("FAIL full_count: peak=%0d holds=%b want %0d 10000", peak_cnt, wr_hold, WB_DEPTH);
    end
    idle(8);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 1'b0, AW'(16'h0020 + i), '0, nh);
      idle(1);
      n_checks++;
      if (obs_v !== 1'b1 || obs_d !== DW'(16'hA000 + i)) begin
        n_fail++;
        $display("FAIL readback_%0d: valid=%b data=%h want 1 %h", i, obs_v, obs_d,
                 DW'(16'hA000 + i));
      end
    end
    n_checks++;
    if (div) begin
      n_fail++;
      $display("FAIL b2b_model: %s", div_note);
    end
  endtask

  task automatic test_youngest();
    int nh;
    idle(8);
    div = 0;
    do_req(1'b1, 1'b0, 16'h003A, '0, nh);
    do_req(1'b0, 1'b1, 16'h0030, 16'h1111, nh);
    do_req(1'b1, 1'b0, 16'h003B, '0, nh);
    do_req(1'b0, 1'b1, 16'h0030, 16'h2222, nh);
    n_checks++;
    if (wbq.size() != 2 || obs_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL young_setup: cnt=%0d want 1 before second push", obs_cnt);
    end
    do_req(1'b1, 1'b0, 16'h0030, '0, nh);
    idle(1);
    n_checks++;
    if (nh !== 0 || obs_v !== 1'b1 || obs_d !== 16'h2222 || div) begin
      n_fail++;
      $display("FAIL youngest: hold=%0d valid=%b data=%h want 0 1 2222 (%s)",
               nh, obs_v, obs_d, div_note);
    end
  endtask

  task automatic test_reset_mid_read();
    int nh;
    logic saw_v;
    idle(8);
    div = 0;
    do_req(1'b1, 1'b0, 16'h003A, '0, nh);
    do_req(1'b0, 1'b1, 16'h0005, 16'h5555, nh);
    step(1'b1, 1'b0, 16'h003B, '0);
    step(1'b1, 1'b0, 16'h003B, '0);
    // DUT is now on its last busy cycle for the 0x3B miss.
    req_re = 0; req_we = 0;
    rst_n  = 1'b0;
    #2;
    n_checks++;
    if (hold !== 1'b0 || wb_count !== '0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: hold=%b cnt=%0d valid=%b want 0 0 0", hold, wb_count,
               rsp_valid);
    end
    saw_v = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_v |= rsp_valid;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    idle(2);
    n_checks++;
    if ((saw_v | obs_v) !== 1'b0 || obs_cnt !== '0 || div) begin
      n_fail++;
      $display("FAIL rst_mid_pulse: valid seen=%b cnt=%0d want 0 0 (%s)", saw_v | obs_v,
               obs_cnt, div_note);
    end
    // The posted write to 0x05 was discarded.
    do_req(1'b1, 1'b0, 16'h0005, '0, nh);
    idle(1);
    n_checks++;
    if (obs_v !== 1'b1 || obs_d !== init_val[5]) begin
      n_fail++;
      $display("FAIL rst_discard: valid=%b data=%h want 1 %h", obs_v, obs_d, init_val[5]);
    end
  endtask

  task automatic test_err();
    int nh;
    div = 0;
    n_checks++;
    if (obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b want 0", obs_err);
    end
    do_req(1'b1, 1'b1, 16'h0006, 16'h6666, nh);
    idle(4);
    n_checks++;
    if (obs_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b want 1", obs_err);
    end
    do_req(1'b1, 1'b0, 16'h0006, '0, nh);
    idle(1);
    n_checks++;
    if (obs_v !== 1'b1 || obs_d !== 16'h6666 || obs_err !== 1'b1 || div) begin
      n_fail++;
      $display("FAIL err_as_write: valid=%b data=%h err=%b want 1 6666 1 (%s)",
               obs_v, obs_d, obs_err, div_note);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    idle(1);
    n_checks++;
    if (obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: err=%b want 0", obs_err);
    end
  endtask

  task automatic test_random();
    int nh;
    int unsigned op;
    logic [AW-1:0] a;
    for (int it = 0; it < 400; it++) begin
      div = 0;
      op = $urandom_range(0, 9);
      // Upper bits vary freely to exercise aliasing.
      a  = (AW'($urandom) & 16'hFF00) | AW'($urandom_range(0, 63));
      if (op < 4)      do_req(1'b0, 1'b1, a, DW'($urandom), nh);
      else if (op < 9) do_req(1'b1, 1'b0, a, '0, nh);
      else begin idle(1); nh = 0; end
      n_checks++;
      if (div || nh < 0) begin
        n_fail++;
        $display("FAIL random_%0d: hold cycles=%0d (%s)", it, nh, div_note);
      end
    end
  endtask

  initial begin
    peak_cnt = 0;
    div      = 0;
    div_note = "";
    test_reset();
    test_init();
    test_forward();
    test_miss_latency();
    test_back_to_back();
    test_youngest();
    test_reset_mid_read();
    test_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
